serial_tx_feeder: RTL and testbench

SERIAL_TX_FEEDER -- requirements
Module: serial_tx_feeder

---
 rtl/serial_tx_feeder.sv | 181 ++++++++++++++++++
 tb/tb_serial_tx_feeder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_feeder.sv
// Byte queue feeding an RS232 transmit core: circular FIFO plus a handshake FSM that
// holds the transaction open across back-to-back bytes and drops a byte on copy timeout.
module serial_tx_feeder #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned GUARD_CYCLES = 10,
  parameter int unsigned CLOSE_CYCLES = 10,
  parameter int unsigned COPY_TIMEOUT = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx_transaction,
  output logic [7:0]                    tx_data,
  output logic                          tx_data_ready,
  input  logic                          tx_data_copied,
  output logic                          tx_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  localparam logic [LvlW-1:0] FullLvl  = LvlW'(FIFO_DEPTH);
  localparam logic [15:0]     GuardCnt = 16'(GUARD_CYCLES);
  localparam logic [15:0]     CloseCnt = 16'(CLOSE_CYCLES);
  localparam logic [15:0]     CopyCnt  = 16'(COPY_TIMEOUT);

  typedef enum logic [2:0] {StIdle, StLoad, StCopied, StGuard, StClose} state_e;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q, level_d;
  logic            push, pop;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        txn_q, txn_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  data_q, data_d;
  logic        tmo_q, tmo_d;

  assign in_ready       = (level_q != FullLvl);
  assign push           = in_valid && in_ready;
  assign fifo_level     = level_q;
  assign tx_transaction = txn_q;
  assign tx_data        = data_q;
  assign tx_data_ready  = rdy_q;
  assign tx_timeout     = tmo_q;

  // ---------------------------------------------------------------------------
  // Circular byte queue
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  // The counter holds cycles already spent in the state; the limit is tested on the
  // incremented value so a state lasts exactly its configured number of cycles.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    txn_d   = txn_q;
    rdy_d   = rdy_q;
    data_d  = data_q;
    tmo_d   = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        txn_d = 1'b0;
        rdy_d = 1'b0;
        if (level_q != '0) begin
          pop     = 1'b1;
          data_d  = mem[rd_ptr_q];
          txn_d   = 1'b1;
          rdy_d   = 1'b1;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d = cnt_inc;
        if (tx_data_copied) begin
          state_d = StCopied;
        end else if (cnt_inc == CopyCnt) begin
          tmo_d   = 1'b1;
          rdy_d   = 1'b0;
          cnt_d   = '0;
          state_d = StClose;
        end
      end
      StCopied: begin
        if (!tx_data_copied) begin
          cnt_d   = '0;
          state_d = StGuard;
        end
      end
      StGuard: begin
        cnt_d = cnt_inc;
        if (cnt_inc == GuardCnt) begin
          rdy_d   = 1'b0;
          cnt_d   = '0;
          state_d = StClose;
        end
      end
      StClose: begin
        rdy_d = 1'b0;
        if (level_q != '0) begin
          // Next byte reuses the open transaction.
          pop     = 1'b1;
          data_d  = mem[rd_ptr_q];
          rdy_d   = 1'b1;
          cnt_d   = '0;
          state_d = StLoad;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CloseCnt) begin
            txn_d   = 1'b0;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        txn_d   = 1'b0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      txn_q   <= 1'b0;
      rdy_q   <= 1'b0;
      data_q  <= 8'h00;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      txn_q   <= txn_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_feeder.sv
// Directed bench for serial_tx_feeder: single byte timing, full-queue burst, copy
// timeout, reset mid-transfer and re-open during the close window.
module tb_serial_tx_feeder;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx_transaction;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_data_copied;
  logic       tx_timeout;
  logic [3:0] fifo_level;

  int n_checks  = 0;
  int n_fail    = 0;
  int txn_drops = 0;

  serial_tx_feeder dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .tx_transaction (tx_transaction),
    .tx_data        (tx_data),
    .tx_data_ready  (tx_data_ready),
    .tx_data_copied (tx_data_copied),
    .tx_timeout     (tx_timeout),
    .fifo_level     (fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_txn"},      tx_transaction, 0);
    chk({tag, "_rdy"},      tx_data_ready,  0);
    chk({tag, "_data"},     tx_data,        0);
    chk({tag, "_tmo"},      tx_timeout,     0);
    chk({tag, "_level"},    fifo_level,     0);
    chk({tag, "_in_ready"}, in_ready,       1);
  endtask

  // Waits for the next byte, checks it, runs the copied handshake and returns on the
  // first sample with tx_data_ready low.
  task automatic send_expect(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (tx_data_ready !== 1'b1 && n < 200) begin
      if (tx_transaction !== 1'b1) txn_drops++;
      tick();
      n++;
    end
    chk({tag, "_rdy"},  tx_data_ready, 1);
    chk({tag, "_data"}, tx_data,       exp);
    tx_data_copied = 1'b1;
    tick();
    tx_data_copied = 1'b0;
    n = 0;
    while (tx_data_ready === 1'b1 && n < 200) begin
      if (tx_transaction !== 1'b1) txn_drops++;
      tick();
      n++;
    end
  endtask

  initial begin
    int g;
    int c;
    int high;
    int pulses;
    int bad;

    rst            = 1'b0;
    in_data        = 8'h00;
    in_valid       = 1'b0;
    tx_data_copied = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_reset_outputs("reset");

    // Single byte 0x41; push lands on the first edge after reset release.
    repeat (2) tick();
    rst      = 1'b0;
    in_data  = 8'h41;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_level_after_push", fifo_level, 1);
    chk("single_rdy_before_pop",   tx_data_ready, 0);
    tick();
    chk("single_rdy",   tx_data_ready,  1);
    chk("single_data",  tx_data,        8'h41);
    chk("single_txn",   tx_transaction, 1);
    chk("single_level", fifo_level,     0);
    repeat (2) tick();
    tx_data_copied = 1'b1;
    repeat (2) tick();
    chk("single_data_copied", tx_data, 8'h41);
    chk("single_rdy_copied",  tx_data_ready, 1);
    tx_data_copied = 1'b0;
    g = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_data_ready !== 1'b1) break;
      g++;
    end
    chk("single_guard_cycles", g, 10);
    c = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_transaction !== 1'b1) break;
      c++;
      tick();
    end
    chk("single_close_cycles", c, 10);

    // Burst: leader 0x40 parks in LOAD while 0x01..0x08 fill the queue.
    in_data  = 8'h40;
    in_valid = 1'b1;
    tick();
    for (int b = 1; b <= 8; b++) begin
      in_data = 8'(b);
      tick();
    end
    in_data = 8'h09;
    chk("burst_level_full",    fifo_level,    8);
    chk("burst_in_ready_full", in_ready,      0);
    chk("burst_leader_data",   tx_data,       8'h40);
    tick();
    chk("burst_ninth_refused", fifo_level,    8);
    tx_data_copied = 1'b1;
    tick();
    tx_data_copied = 1'b0;
    g = 0;
    while (tx_data_ready === 1'b1 && g < 100) begin tick(); g++; end
    g = 0;
    while (tx_data_ready !== 1'b1 && g < 100) begin
      if (tx_transaction !== 1'b1) txn_drops++;
      tick();
      g++;
    end
    chk("pop_at_full_level",    fifo_level, 7);
    chk("pop_at_full_in_ready", in_ready,   1);
    chk("pop_at_full_data",     tx_data,    8'h01);
    tick();
    in_valid = 1'b0;
    chk("burst_ninth_accepted", fifo_level, 8);
    for (int b = 1; b <= 9; b++) begin
      send_expect($sformatf("burst_%0d", b), 8'(b));
    end
    chk("burst_txn_drops", txn_drops, 0);
    g = 0;
    while (tx_transaction === 1'b1 && g < 100) begin tick(); g++; end
    chk("burst_closed_txn",   tx_transaction, 0);
    chk("burst_closed_level", fifo_level,     0);

    // Copy timeout: 0x55 is held for exactly COPY_TIMEOUT cycles then dropped.
    in_data  = 8'h55;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("tmo_rdy",  tx_data_ready, 1);
    chk("tmo_data", tx_data,       8'h55);
    high   = 1;
    pulses = 0;
    for (int i = 0; i < 60000; i++) begin
      tick();
      if (tx_timeout === 1'b1) pulses++;
      if (tx_data_ready !== 1'b1) break;
      high++;
    end
    chk("tmo_load_cycles", high,           50000);
    chk("tmo_txn_held",    tx_transaction, 1);
    repeat (5) begin
      tick();
      if (tx_timeout === 1'b1) pulses++;
    end
    chk("tmo_pulse_count", pulses, 1);
    in_data  = 8'h56;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    send_expect("tmo_next", 8'h56);
    g = 0;
    while (tx_transaction === 1'b1 && g < 100) begin tick(); g++; end
    chk("tmo_closed_txn", tx_transaction, 0);

    // Reset while in COPIED with three bytes queued.
    in_valid = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      in_data = 8'hA0 + 8'(b);
      tick();
    end
    in_valid = 1'b0;
    chk("rst_level_before", fifo_level, 3);
    tx_data_copied = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    tx_data_copied = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      tick();
      if (tx_data_ready !== 1'b0 || tx_transaction !== 1'b0 || fifo_level !== 4'd0) bad++;
    end
    chk("rst_no_emit", bad, 0);
    in_data  = 8'hB0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rst_new_rdy",  tx_data_ready,  1);
    chk("rst_new_data", tx_data,        8'hB0);
    chk("rst_new_txn",  tx_transaction, 1);
    send_expect("rst_new", 8'hB0);

    // Push in CLOSE when the counter reaches 5: ready returns without dropping txn.
    repeat (5) tick();
    in_data  = 8'h77;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("close_push_rdy",   tx_data_ready,  0);
    chk("close_push_txn",   tx_transaction, 1);
    chk("close_push_level", fifo_level,     1);
    tick();
    chk("close_reopen_rdy",  tx_data_ready,  1);
    chk("close_reopen_data", tx_data,        8'h77);
    chk("close_reopen_txn",  tx_transaction, 1);
    send_expect("close_reopen", 8'h77);
    chk("final_txn_drops", txn_drops, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
